apb_slave_regfile: RTL

// APB responder sitting downstream of the bridge's APB-side outputs (Pselx/Penable/Pwrite/Paddr/Pwdata).

---
 rtl/apb_slave_regfile.sv | 101 ++++++++++
 1 files changed

// File: rtl/apb_slave_regfile.sv
// APB register-file responder: DEPTH x 32-bit words with programmable wait
// states and a slave-error response for misaligned or out-of-window addresses.
module apb_slave_regfile #(
  parameter int unsigned SLAVE_ID    = 0,
  parameter int unsigned DEPTH       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]       state;
  logic [3:0]       cnt;
  logic [IDX_W-1:0] idx_q;
  logic             err_q;
  logic             write_q;
  logic [31:0]      wdata_q;
  logic [31:0]      mem [DEPTH];

  logic             sel;
  logic [31:0]      off;
  logic             dec_err;
  logic [IDX_W-1:0] dec_idx;

  // Only our own select bit matters; the others belong to sibling slaves.
  logic unused_sel_bits;
  assign unused_sel_bits = ^Pselx;

  assign sel = Pselx[SLAVE_ID];

  // Wrap-around of the subtraction is caught by the Paddr < BASE_ADDR term.
  always_comb begin
    off     = Paddr - BASE_ADDR;
    dec_err = (Paddr < BASE_ADDR) || (off[1:0] != 2'b00) || ((off >> 2) >= 32'(DEPTH));
    dec_idx = off[IDX_W+1:2];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
      // NOTE: the register file itself is cleared on reset, so it is built
      // from flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (sel && !Penable) begin
            idx_q   <= dec_idx;
            err_q   <= dec_err;
            write_q <= Pwrite;
            wdata_q <= Pwdata;
            cnt     <= 4'(WAIT_STATES);
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!(sel && Penable)) begin
            state <= IDLE;  // protocol violation: drop the transfer silently
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (write_q && !err_q) begin
              mem[idx_q] <= wdata_q;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state, never on the live bus.
  assign Pready  = (state == ACCESS) && (cnt == 4'd0);
  assign Pslverr = Pready && err_q;
  assign Prdata  = (Pready && !write_q && !err_q) ? mem[idx_q] : 32'h0;

endmodule
